layer_write_arbiter: RTL and testbench

- Shares the single write port of the layered frame store between N_REQ drawing requesters (cursor, draw layers) and an internal layer-clear sequencer.
- The frame store is the one the compositor scans.
- The compositor's scan read has absolute priority: no write is issued while scan_busy is high.
- Requester grants are round-robin. All memory-side outputs are registered (1-cycle latency).

---
 rtl/layer_write_arbiter_if.sv | 37 +++
 rtl/layer_write_arbiter.sv | 128 ++++++++++++
 tb/tb_layer_write_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/layer_write_arbiter_if.sv
// Requester and frame-store write bus for layer_write_arbiter.
// master = requester/memory side, slave = arbiter.
interface layer_write_arbiter_if #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned LAYER_BITS  = 3
);
  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned IW = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ*XW-1:0]          req_x;
  logic [N_REQ*YW-1:0]          req_y;
  logic [N_REQ*COLOR_WIDTH-1:0] req_color;
  logic [N_REQ*LAYER_BITS-1:0]  req_layer;

  logic                   mem_we;
  logic [XW-1:0]          mem_x;
  logic [YW-1:0]          mem_y;
  logic [COLOR_WIDTH-1:0] mem_color;
  logic [LAYER_BITS-1:0]  mem_layer;
  logic [IW-1:0]          grant_id;

  modport master (
    output req_valid, req_x, req_y, req_color, req_layer,
    input  req_ready, mem_we, mem_x, mem_y, mem_color, mem_layer, grant_id
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, req_layer,
    output req_ready, mem_we, mem_x, mem_y, mem_color, mem_layer, grant_id
  );
endinterface

// File: rtl/layer_write_arbiter.sv
// Round-robin arbiter for the layered frame store write port, with a
// built-in layer-clear sequencer; compositor scan reads block all writes.
module layer_write_arbiter #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned LAYER_BITS  = 3,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_busy,
  input  logic                  clear_start,
  input  logic [LAYER_BITS-1:0] clear_layer,
  output logic                  clear_busy,
  output logic                  clear_done,
  layer_write_arbiter_if.slave  bus
);
  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned IW = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_q;
  logic [XW-1:0]         cx_q;
  logic [YW-1:0]         cy_q;
  logic [LAYER_BITS-1:0] clr_layer_q;

  logic          grant_hit;
  logic [IW-1:0] grant_idx;
  logic          clr_issue;
  logic          clr_last;
  logic          cx_last;
  logic [N_REQ-1:0] ready_c;
  int unsigned   idx;

  assign cx_last       = (cx_q == XW'(WIDTH - 1));
  assign clear_busy    = (state_q == CLEAR);
  assign bus.req_ready = ready_c;

  // Next state, grant selection and clear-write issue
  always_comb begin
    state_d   = state_q;
    ready_c   = '0;
    grant_hit = 1'b0;
    grant_idx = '0;
    clr_issue = 1'b0;
    clr_last  = 1'b0;
    idx       = 0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
        end else if (!scan_busy) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_q) + i) % N_REQ;
            if (!grant_hit && bus.req_valid[IW'(idx)]) begin
              grant_hit = 1'b1;
              grant_idx = IW'(idx);
            end
          end
          if (grant_hit) ready_c[grant_idx] = 1'b1;
        end
      end
      CLEAR: begin
        if (!scan_busy) begin
          clr_issue = 1'b1;
          clr_last  = cx_last && (cy_q == YW'(HEIGHT - 1));
          if (clr_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered write port, round-robin pointer and clear address counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q          <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      clr_layer_q   <= '0;
      clear_done    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_x     <= '0;
      bus.mem_y     <= '0;
      bus.mem_color <= '0;
      bus.mem_layer <= '0;
      bus.grant_id  <= '0;
    end else begin
      clear_done <= clr_issue && clr_last;
      bus.mem_we <= grant_hit || clr_issue;
      if (grant_hit) begin
        rr_q          <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
        bus.mem_x     <= bus.req_x[32'(grant_idx)*XW +: XW];
        bus.mem_y     <= bus.req_y[32'(grant_idx)*YW +: YW];
        bus.mem_color <= bus.req_color[32'(grant_idx)*COLOR_WIDTH +: COLOR_WIDTH];
        bus.mem_layer <= bus.req_layer[32'(grant_idx)*LAYER_BITS +: LAYER_BITS];
        bus.grant_id  <= grant_idx;
      end else if (clr_issue) begin
        bus.mem_x     <= cx_q;
        bus.mem_y     <= cy_q;
        bus.mem_color <= COLOR_NONE;
        bus.mem_layer <= clr_layer_q;
        bus.grant_id  <= '0;
        if (cx_last) begin
          cx_q <= '0;
          cy_q <= clr_last ? '0 : cy_q + YW'(1);
        end else begin
          cx_q <= cx_q + XW'(1);
        end
      end
      if (state_q == IDLE && clear_start) begin
        clr_layer_q <= clear_layer;
        cx_q        <= '0;
        cy_q        <= '0;
      end
    end
  end
endmodule

// File: tb/tb_layer_write_arbiter.sv
// Directed bench for layer_write_arbiter: stimulus pushes expected writes
// into a queue, a negedge monitor pops and compares each mem_we beat.
module tb_layer_write_arbiter;
  localparam int unsigned W = 4, H = 3, N = 4, CW = 8, LB = 3;
  localparam logic [CW-1:0] CNONE = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scan_busy = 1'b0;
  logic          clear_start = 1'b0;
  logic [LB-1:0] clear_layer = '0;
  logic          clear_busy, clear_done;

  layer_write_arbiter_if #(.WIDTH(W), .HEIGHT(H), .N_REQ(N), .COLOR_WIDTH(CW),
                           .LAYER_BITS(LB)) bus ();

  layer_write_arbiter #(.WIDTH(W), .HEIGHT(H), .N_REQ(N), .COLOR_WIDTH(CW),
                        .LAYER_BITS(LB), .COLOR_NONE(CNONE)) dut (
    .clk(clk), .reset(reset), .scan_busy(scan_busy),
    .clear_start(clear_start), .clear_layer(clear_layer),
    .clear_busy(clear_busy), .clear_done(clear_done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    x;
    logic [1:0]    y;
    logic [CW-1:0] c;
    logic [LB-1:0] l;
    logic [1:0]    g;
    logic          d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]    tx[N];
  logic [1:0]    ty[N];
  logic [CW-1:0] tc[N];
  logic [LB-1:0] tl[N];
  int            rr_seq[8] = '{2, 3, 0, 1, 2, 3, 0, 1};
  int            pr_seq[3] = '{1, 3, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < int'(N); i++) begin
      bus.req_x[i*2 +: 2]      = tx[i];
      bus.req_y[i*2 +: 2]      = ty[i];
      bus.req_color[i*CW +: CW] = tc[i];
      bus.req_layer[i*LB +: LB] = tl[i];
    end
  endtask

  task automatic push_req(input int g);
    exp_t e;
    e.x = tx[g]; e.y = ty[g]; e.c = tc[g]; e.l = tl[g]; e.g = 2'(g); e.d = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_clear(input logic [LB-1:0] l, input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      e.x = 2'(k % int'(W)); e.y = 2'(k / int'(W)); e.c = CNONE; e.l = l; e.g = 2'd0;
      e.d = (k == int'(W*H) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic sbusy, input logic cs,
                      input logic [LB-1:0] cl);
    @(negedge clk);
    bus.req_valid = v;
    scan_busy     = sbusy;
    clear_start   = cs;
    clear_layer   = cl;
    #1;
  endtask

  // Monitor: every write beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got x=%0d y=%0d layer=%0d, expected no write",
                   bus.mem_x, bus.mem_y, bus.mem_layer);
        end else begin
          mon_e = sb.pop_front();
          chk("mem_x", 32'(bus.mem_x), 32'(mon_e.x));
          chk("mem_y", 32'(bus.mem_y), 32'(mon_e.y));
          chk("mem_color", 32'(bus.mem_color), 32'(mon_e.c));
          chk("mem_layer", 32'(bus.mem_layer), 32'(mon_e.l));
          chk("grant_id", 32'(bus.grant_id), 32'(mon_e.g));
          chk("clear_done", 32'(clear_done), 32'(mon_e.d));
        end
      end else begin
        chk("done_without_write", 32'(clear_done), 32'd0);
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    for (int i = 0; i < int'(N); i++) begin
      tx[i] = '0; ty[i] = '0; tc[i] = '0; tl[i] = '0;
    end
    drive_fields();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step('0, 1'b0, 1'b0, '0);
    chk("idle_ready", 32'(bus.req_ready), 32'd0);

    // Single write from requester 1
    tx[1] = 2'd2; ty[1] = 2'd1; tc[1] = 8'd5; tl[1] = 3'd3;
    drive_fields();
    step(4'b0010, 1'b0, 1'b0, '0);
    chk("single_ready", 32'(bus.req_ready), 32'b0010);
    push_req(1);
    step('0, 1'b0, 1'b0, '0);

    // Round robin with all valid, pointer now at 2
    tx = '{2'd0, 2'd1, 2'd2, 2'd3};
    ty = '{2'd0, 2'd1, 2'd2, 2'd0};
    tc = '{8'h10, 8'h11, 8'h12, 8'h13};
    tl = '{3'd1, 3'd2, 3'd3, 3'd4};
    drive_fields();
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b0, 1'b0, '0);
      chk("rr_ready", 32'(bus.req_ready), 32'(1) << rr_seq[k]);
      push_req(rr_seq[k]);
    end
    step('0, 1'b0, 1'b0, '0);

    // Scan priority blocks requester 0 for three cycles
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b1, 1'b0, '0);
      chk("scan_ready", 32'(bus.req_ready), 32'd0);
    end
    step(4'b0001, 1'b0, 1'b0, '0);
    chk("scan_release_ready", 32'(bus.req_ready), 32'b0001);
    push_req(0);

    // Sparse valid: pointer at 1, requesters 1 and 3 alternate
    for (int k = 0; k < 3; k++) begin
      step(4'b1010, 1'b0, 1'b0, '0);
      chk("sparse_ready", 32'(bus.req_ready), 32'(1) << pr_seq[k]);
      push_req(pr_seq[k]);
    end
    step('0, 1'b0, 1'b0, '0);

    // Clear layer 2 with all requesters valid; clear_start mid-clear ignored
    step(4'b1111, 1'b0, 1'b1, 3'd2);
    chk("clear_start_ready", 32'(bus.req_ready), 32'd0);
    push_clear(3'd2, int'(W*H));
    for (int k = 1; k <= int'(W*H); k++) begin
      step(4'b1111, 1'b0, k == 5, 3'd5);
      chk("clear_ready", 32'(bus.req_ready), 32'd0);
      chk("clear_busy", 32'(clear_busy), 32'd1);
    end
    step(4'b1111, 1'b0, 1'b0, '0);
    chk("post_clear_busy", 32'(clear_busy), 32'd0);
    chk("post_clear_ready", 32'(bus.req_ready), 32'b0100);
    push_req(2);
    step('0, 1'b0, 1'b0, '0);

    // Clear layer 4 with scan_busy toggling
    step('0, 1'b0, 1'b1, 3'd4);
    push_clear(3'd4, int'(W*H));
    for (int k = 0; k < 2*int'(W*H); k++) begin
      step(4'b0001, (k % 2) == 0, 1'b0, '0);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_busy", 32'(clear_busy), 32'd1);
    end
    step('0, 1'b0, 1'b0, '0);
    chk("stall_done_busy", 32'(clear_busy), 32'd0);
    step('0, 1'b0, 1'b0, '0);

    // Clear layer 1, reset after five writes
    step('0, 1'b0, 1'b1, 3'd1);
    push_clear(3'd1, 5);
    for (int k = 0; k < 5; k++) step('0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_mem_y", 32'(bus.mem_y), 32'd0);
    chk("abort_mem_color", 32'(bus.mem_color), 32'd0);
    chk("abort_mem_layer", 32'(bus.mem_layer), 32'd0);
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_done", 32'(clear_done), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) step('0, 1'b0, 1'b0, '0);
    chk("abort_idle_busy", 32'(clear_busy), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
